// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the byte-serial instruction fetch unit
package fetch_pkg;

  localparam int INST_W         = 32;
  localparam int BYTES_PER_INST = 4;
  localparam int MEM_RD_LAT_MIN = 1;
  localparam int MEM_RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/fetch_byte_asm.sv
// rtl/fetch_byte_asm.sv - little-endian byte-to-word assembler; o_word already includes the byte written this cycle
module fetch_byte_asm
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_byte,
  input  logic [1:0]        i_idx,
  input  logic              i_we,
  input  logic              i_clear,
  output logic [INST_W-1:0] o_word
);

  logic [INST_W-1:0] r_word;
  logic [INST_W-1:0] w_merge;

  always_comb begin
    w_merge = r_word;
    if (i_we) begin
      w_merge[{i_idx, 3'b000} +: 8] = i_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
    end else if (i_clear) begin
      r_word <= '0;
    end else begin
      r_word <= w_merge;
    end
  end

  assign o_word = w_merge;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch FSM; define FETCH_BUF_EN for a one-entry output buffer
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] pc_i,
  input  logic              pc_ce_i,
  output logic              pc_ready_o,
  input  logic              flush_i,
  output logic [INST_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [7:0]        mem_din_i,
  output logic [INST_W-1:0] inst_o,
  output logic [INST_W-1:0] inst_pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i
);

  fetch_state_e          r_state;
  logic [INST_W-1:0]     r_pc;
  logic [2:0]            r_issue;
  logic [1:0]            r_cnt;
  logic [1:0]            r_drain;
  logic [MEM_RD_LAT-1:0] r_rd_pipe;
  logic                  w_accept;
  logic                  w_cap;
  logic                  w_done;
  logic [INST_W-1:0]     w_word;

  assign pc_ready_o = (r_state == S_IDLE) && !flush_i;
  assign w_accept   = pc_ready_o && pc_ce_i;
  // A byte is only taken while fetching, so bytes landing in DRAIN or after reset are dropped.
  assign w_cap      = r_rd_pipe[MEM_RD_LAT-1] && (r_state == S_FETCH);
  assign w_done     = w_cap && (r_cnt == 2'(BYTES_PER_INST - 1));

  fetch_byte_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .i_byte  (mem_din_i),
    .i_idx   (r_cnt),
    .i_we    (w_cap),
    .i_clear (w_accept),
    .o_word  (w_word)
  );

  generate
    if (MEM_RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_pipe <= '0;
        else      r_rd_pipe <= mem_rd_o;
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rd_pipe <= '0;
        else      r_rd_pipe <= {r_rd_pipe[MEM_RD_LAT-2:0], mem_rd_o};
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= '0;
      r_issue      <= '0;
      r_cnt        <= '0;
      r_drain      <= '0;
      mem_addr_o   <= '0;
      mem_rd_o     <= 1'b0;
      inst_o       <= '0;
      inst_pc_o    <= '0;
      inst_valid_o <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            inst_valid_o <= 1'b0;
          end else begin
`ifdef FETCH_BUF_EN
            if (inst_valid_o && inst_ready_i) inst_valid_o <= 1'b0;
`endif
            if (pc_ce_i) begin
              r_pc       <= pc_i;
              mem_addr_o <= pc_i;
              mem_rd_o   <= 1'b1;
              r_issue    <= 3'd1;
              r_cnt      <= '0;
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (flush_i) begin
            mem_rd_o <= 1'b0;
            r_drain  <= '0;
            r_state  <= S_DRAIN;
`ifdef FETCH_BUF_EN
            inst_valid_o <= 1'b0;
`endif
          end else begin
            if (mem_rd_o) begin
              if (r_issue == 3'(BYTES_PER_INST)) begin
                mem_rd_o <= 1'b0;
              end else begin
                mem_addr_o <= mem_addr_o + 1'b1;
                r_issue    <= r_issue + 1'b1;
              end
            end
            if (w_cap) r_cnt <= r_cnt + 1'b1;
`ifdef FETCH_BUF_EN
            if (inst_valid_o && inst_ready_i) inst_valid_o <= 1'b0;
            if (w_done) begin
              // Buffer free (or emptied this edge): hand the word over and start the next fetch.
              if (!inst_valid_o || inst_ready_i) begin
                inst_o       <= w_word;
                inst_pc_o    <= r_pc;
                inst_valid_o <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_state <= S_HOLD;
              end
            end
`else
            if (w_done) begin
              inst_o       <= w_word;
              inst_pc_o    <= r_pc;
              inst_valid_o <= 1'b1;
              r_state      <= S_HOLD;
            end
`endif
          end
        end
        S_DRAIN: begin
          if (r_drain == 2'(MEM_RD_LAT - 1)) r_state <= S_IDLE;
          else                               r_drain <= r_drain + 1'b1;
        end
        S_HOLD: begin
          if (flush_i) begin
            inst_valid_o <= 1'b0;
            r_state      <= S_IDLE;
          end else if (inst_ready_i) begin
`ifdef FETCH_BUF_EN
            inst_o    <= w_word;
            inst_pc_o <= r_pc;
`else
            inst_valid_o <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter MEM_RD_LAT, default 1, meaning cycles from mem_rd_o high to valid mem_din_i; only 1 and 2 are legal.
REQ-002 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pc_i, input, 32, fetch address from the PC stage.
REQ-005 SHALL have port pc_ce_i, input, 1, pc_i valid.
REQ-006 SHALL have port pc_ready_o, output, 1, fetch unit accepts pc_i this cycle.
REQ-007 SHALL have port flush_i, input, 1, synchronous redirect/abort.
REQ-008 SHALL have port mem_addr_o, output, 32, byte address to memory.
REQ-009 SHALL have port mem_rd_o, output, 1, byte read strobe.
REQ-010 SHALL have port mem_din_i, input, 8, read data byte.
REQ-011 SHALL have port inst_o, output, 32, assembled instruction.
REQ-012 SHALL have port inst_pc_o, output, 32, address of inst_o.
REQ-013 SHALL have port inst_valid_o, output, 1, inst_o/inst_pc_o valid.
REQ-014 SHALL have port inst_ready_i, input, 1, decode consumes inst_o.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, DRAIN, HOLD; pc_ready_o = (state==IDLE) && !flush_i.
REQ-016 SHALL accept pc_i at an edge where pc_ce_i && pc_ready_o; latch it, go IDLE->FETCH.
REQ-017 In FETCH SHALL drive mem_rd_o=1 for 4 consecutive cycles with mem_addr_o = pc, pc+1, pc+2, pc+3 (32-bit wrap: 0xFFFFFFFF+1 = 0x00000000).
REQ-018 SHALL place byte k (address pc+k) in inst_o[8k+7:8k] (little-endian); no alignment check.
REQ-019 SHALL assert inst_valid_o from edge N+4+MEM_RD_LAT (N = accepting edge) and enter HOLD; 5 cycles for default.
REQ-020 In HOLD SHALL keep inst_o/inst_pc_o stable while inst_valid_o && !inst_ready_i; on inst_ready_i drop inst_valid_o next edge, go IDLE.
REQ-021 mem_rd_o SHALL be 0 outside FETCH; mem_addr_o holds last value.
REQ-022 flush_i in FETCH SHALL stop strobes next edge, go DRAIN for MEM_RD_LAT cycles discarding returned bytes, then IDLE.
REQ-023 flush_i in HOLD or IDLE SHALL clear inst_valid_o next edge and go IDLE; flush_i has priority over inst_ready_i and pc_ce_i.
REQ-024 Simultaneous inst_ready_i and completion SHALL not drop or duplicate an instruction.

Reset
REQ-025 rst low SHALL immediately force state IDLE, inst_valid_o=0, mem_rd_o=0, mem_addr_o=0, inst_o=0, inst_pc_o=0, byte counter 0.
REQ-026 Reset mid-FETCH SHALL discard the partial instruction; late memory bytes after release SHALL be ignored.

Configuration
REQ-027 Macro FETCH_BUF_EN defined SHALL add a one-entry output buffer: on completion the instruction moves to the buffer and the FSM returns IDLE if the buffer is empty or consumed that cycle, else waits in HOLD; flush_i clears the buffer.
REQ-028 FETCH_BUF_EN undefined SHALL give REQ-019/020 behaviour: no new fetch until inst_ready_i.

Structure
REQ-029 Package fetch_pkg SHALL hold the state enum, INST_W=32, BYTES_PER_INST=4, legal MEM_RD_LAT bounds.
REQ-030 Byte shifting/assembly SHALL be sub-module fetch_byte_asm (byte in, index, clear, 32-bit out).

Verification
REQ-031 Reset release, pc_i=0x00000000, memory bytes 13 00 00 00 -> addrs 0,1,2,3; inst_o=0x00000013, inst_pc_o=0, valid at N+5.
REQ-032 pc_i=0xFFFFFFFE -> mem_addr_o FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-033 inst_ready_i low 10 cycles -> inst_o stable, pc_ready_o=0 (no macro); with FETCH_BUF_EN second fetch completes into HOLD with no loss.
REQ-034 flush_i after 2nd strobe, MEM_RD_LAT=2 -> 2 DRAIN cycles, inst_valid_o never high, next pc_i=0x100 fetched correctly.
REQ-035 rst low during 3rd strobe -> all outputs 0 immediately; next fetch of 0x8 returns correct word.
